// File: rtl/zap_copro_responder.sv
// zap_copro_responder
// Coprocessor-side end of the copro_dav / copro_word / copro_done handshake.
// Accepts MCR, MRC and CDP aimed at CP_NUM, evaluates the condition code
// against the CPSR flags, and executes against a small bank of 32-bit
// coprocessor registers. Register 0 is a read-only ID register.
//
// Timing, counted from the cycle in which dav is first seen in IDLE (cycle 0):
//   MRC, CDP, condition-fail, undefined : done visible in cycle 3
//   MCR                                 : done visible in cycle 4
// The MCR read strobe is visible in cycle 2 and the CPU register file
// returns data in cycle 3. That data is committed on the same edge that
// raises done, so a flush arriving before that edge discards it.

module zap_copro_responder #(
    parameter int          CP_NUM   = 15,
    parameter int          CP_REGS  = 16,
    parameter logic [31:0] ID_VALUE = 32'h4107_0000
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_clear,
    input  logic        i_copro_dav,
    input  logic [31:0] i_copro_word,
    input  logic [31:0] i_cpsr,
    output logic        o_copro_done,
    output logic        o_copro_und,
    output logic        o_reg_rd_en,
    output logic [3:0]  o_reg_rd_addr,
    input  logic [31:0] i_reg_rd_data,
    output logic        o_reg_wr_en,
    output logic [3:0]  o_reg_wr_addr,
    output logic [31:0] o_reg_wr_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_RD_WAIT,
        S_DONE,
        S_WAIT_DROP
    } state_t;

    state_t      r_state;
    logic [31:0] r_word;
    logic [3:0]  r_flags;
    logic        r_und;
    logic        r_mcr_pend;
    logic        r_done;
    logic        r_und_out;
    logic        r_rd_en;
    logic [3:0]  r_rd_addr;
    logic        r_wr_en;
    logic [3:0]  r_wr_addr;
    logic [31:0] r_wr_data;
    logic [31:0] r_creg [0:CP_REGS-1];

    logic [3:0]  w_crn;
    logic [3:0]  w_crd;
    logic [3:0]  w_crm;
    logic [3:0]  w_opc1;
    logic        w_cond_pass;
    logic        w_cp_match;
    logic        w_is_cdp;
    logic        w_is_mrc;
    logic        w_is_mcr;
    logic        w_xfer_idx_ok;
    logic        w_cdp_idx_ok;
    logic [31:0] w_crn_val;
    logic [31:0] w_crm_val;
    logic [31:0] w_cdp_sum;
    logic [31:0] w_cdp_xor;
    logic        w_unused;

    // ARM condition code table on latched flags {N,Z,C,V}; NV is treated as never.
    function automatic logic f_cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n;
        logic z;
        logic c;
        logic v;
        logic pass;
        n = nzcv[3];
        z = nzcv[2];
        c = nzcv[1];
        v = nzcv[0];
        case (cond)
            4'h0:    pass = z;
            4'h1:    pass = !z;
            4'h2:    pass = c;
            4'h3:    pass = !c;
            4'h4:    pass = n;
            4'h5:    pass = !n;
            4'h6:    pass = v;
            4'h7:    pass = !v;
            4'h8:    pass = c && !z;
            4'h9:    pass = !c || z;
            4'hA:    pass = (n == v);
            4'hB:    pass = (n != v);
            4'hC:    pass = !z && (n == v);
            4'hD:    pass = z || (n != v);
            4'hE:    pass = 1'b1;
            default: pass = 1'b0;
        endcase
        return pass;
    endfunction

    // A register index is usable only if the bank actually has that entry.
    function automatic logic f_idx_ok(input logic [3:0] idx);
        return ({28'd0, idx} < CP_REGS);
    endfunction

    assign w_crn  = r_word[19:16];
    assign w_crd  = r_word[15:12];
    assign w_crm  = r_word[3:0];
    assign w_opc1 = r_word[23:20];

    assign w_cond_pass   = f_cond_pass(r_word[31:28], r_flags);
    assign w_cp_match    = (r_word[11:8] == CP_NUM[3:0]);
    assign w_is_cdp      = (r_word[27:24] == 4'b1110) && !r_word[4];
    assign w_is_mrc      = (r_word[27:24] == 4'b1110) && r_word[4] && r_word[20];
    assign w_is_mcr      = (r_word[27:24] == 4'b1110) && r_word[4] && !r_word[20];
    assign w_xfer_idx_ok = f_idx_ok(w_crn);
    assign w_cdp_idx_ok  = f_idx_ok(w_crn) && f_idx_ok(w_crd) && f_idx_ok(w_crm);

    assign w_crn_val = (w_crn == 4'd0) ? ID_VALUE : r_creg[w_crn];
    assign w_crm_val = (w_crm == 4'd0) ? ID_VALUE : r_creg[w_crm];
    assign w_cdp_sum = w_crn_val + w_crm_val;
    assign w_cdp_xor = w_crn_val ^ w_crm_val;

    assign w_unused = &{1'b0, i_cpsr[27:0], r_word[7:5]};

    assign o_copro_done  = r_done;
    assign o_copro_und   = r_und_out;
    assign o_reg_rd_en   = r_rd_en;
    assign o_reg_rd_addr = r_rd_addr;
    assign o_reg_wr_en   = r_wr_en;
    assign o_reg_wr_addr = r_wr_addr;
    assign o_reg_wr_data = r_wr_data;

    // Handshake FSM plus coprocessor register bank; writes to index 0 are dropped.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= S_IDLE;
            r_word     <= '0;
            r_flags    <= '0;
            r_und      <= 1'b0;
            r_mcr_pend <= 1'b0;
            r_done     <= 1'b0;
            r_und_out  <= 1'b0;
            r_rd_en    <= 1'b0;
            r_rd_addr  <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            for (int i = 0; i < CP_REGS; i++) begin
                r_creg[i] <= '0;
            end
        end else begin
            r_done    <= 1'b0;
            r_und_out <= 1'b0;
            r_rd_en   <= 1'b0;
            r_wr_en   <= 1'b0;

            if (i_clear) begin
                r_state    <= i_copro_dav ? S_WAIT_DROP : S_IDLE;
                r_mcr_pend <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_copro_dav) begin
                            r_word  <= i_copro_word;
                            r_flags <= i_cpsr[31:28];
                            r_state <= S_EXEC;
                        end
                    end

                    S_EXEC: begin
                        r_und      <= 1'b0;
                        r_mcr_pend <= 1'b0;
                        r_state    <= S_DONE;
                        if (!w_cond_pass) begin
                            r_und <= 1'b0;
                        end else if (!w_cp_match) begin
                            r_und <= 1'b1;
                        end else if (w_is_mrc) begin
                            if (!w_xfer_idx_ok) begin
                                r_und <= 1'b1;
                            end else if (w_crd != 4'd15) begin
                                r_wr_en   <= 1'b1;
                                r_wr_addr <= w_crd;
                                r_wr_data <= w_crn_val;
                            end
                        end else if (w_is_mcr) begin
                            if (!w_xfer_idx_ok) begin
                                r_und <= 1'b1;
                            end else begin
                                r_rd_en   <= 1'b1;
                                r_rd_addr <= w_crd;
                                r_state   <= S_RD_WAIT;
                            end
                        end else if (w_is_cdp) begin
                            if (!w_cdp_idx_ok) begin
                                r_und <= 1'b1;
                            end else if (w_opc1 == 4'd0) begin
                                if (w_crd != 4'd0) begin
                                    r_creg[w_crd] <= w_cdp_sum;
                                end
                            end else if (w_opc1 == 4'd1) begin
                                if (w_crd != 4'd0) begin
                                    r_creg[w_crd] <= w_cdp_xor;
                                end
                            end else begin
                                r_und <= 1'b1;
                            end
                        end else begin
                            r_und <= 1'b1;
                        end
                    end

                    S_RD_WAIT: begin
                        r_mcr_pend <= 1'b1;
                        r_state    <= S_DONE;
                    end

                    S_DONE: begin
                        r_done     <= 1'b1;
                        r_und_out  <= r_und;
                        r_mcr_pend <= 1'b0;
                        if (r_mcr_pend && (w_crn != 4'd0)) begin
                            r_creg[w_crn] <= i_reg_rd_data;
                        end
                        r_state <= S_WAIT_DROP;
                    end

                    S_WAIT_DROP: begin
                        if (!i_copro_dav) begin
                            r_state <= S_IDLE;
                        end
                    end

                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_zap_copro_responder.sv
// tb_zap_copro_responder
// Directed test of the coprocessor responder. A transaction-level model
// predicts, per cycle, the strobes and done/und pulses; a compare process
// checks the DUT against that prediction on every negative clock edge.

module tb_zap_copro_responder;

    localparam logic [31:0] ID    = 32'h4107_0000;
    localparam int          DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        dav;
    logic [31:0] word;
    logic [31:0] cpsr;
    logic [31:0] rd_data = 32'h0BAD_F00D;
    logic        done;
    logic        und;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;

    int cyc          = 0;
    int n_compared   = 0;
    int n_mismatched = 0;
    int n_done       = 0;
    int last_done_cyc = 0;
    logic [31:0] last_wr_data = '0;
    logic [3:0]  last_wr_addr = '0;
    bit check_en = 1'b0;

    // Expected per-cycle behaviour, indexed by cycle number
    bit          exp_done    [0:DEPTH-1];
    bit          exp_und     [0:DEPTH-1];
    bit          exp_rd_en   [0:DEPTH-1];
    bit [3:0]    exp_rd_addr [0:DEPTH-1];
    bit          exp_wr_en   [0:DEPTH-1];
    bit [3:0]    exp_wr_addr [0:DEPTH-1];
    bit [31:0]   exp_wr_data [0:DEPTH-1];

    // Model state: coprocessor bank and the CPU register file seen by MCR
    logic [31:0] mcreg    [0:15];
    logic [31:0] cpu_regs [0:15];

    zap_copro_responder dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_clear       (clear),
        .i_copro_dav   (dav),
        .i_copro_word  (word),
        .i_cpsr        (cpsr),
        .o_copro_done  (done),
        .o_copro_und   (und),
        .o_reg_rd_en   (rd_en),
        .o_reg_rd_addr (rd_addr),
        .i_reg_rd_data (rd_data),
        .o_reg_wr_en   (wr_en),
        .o_reg_wr_addr (wr_addr),
        .o_reg_wr_data (wr_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Synchronous CPU register file: data appears the cycle after the strobe
    always @(posedge clk) rd_data <= rd_en ? cpu_regs[rd_addr] : 32'h0BAD_F00D;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Per-cycle comparison against the model's prediction
    always @(negedge clk) begin
        if (check_en && cyc < DEPTH) begin
            checkOutput("done",  {31'd0, done},  {31'd0, exp_done[cyc]});
            checkOutput("und",   {31'd0, und},   {31'd0, exp_und[cyc]});
            checkOutput("rd_en", {31'd0, rd_en}, {31'd0, exp_rd_en[cyc]});
            checkOutput("wr_en", {31'd0, wr_en}, {31'd0, exp_wr_en[cyc]});
            if (exp_rd_en[cyc]) checkOutput("rd_addr", {28'd0, rd_addr}, {28'd0, exp_rd_addr[cyc]});
            if (exp_wr_en[cyc]) begin
                checkOutput("wr_addr", {28'd0, wr_addr}, {28'd0, exp_wr_addr[cyc]});
                checkOutput("wr_data", wr_data, exp_wr_data[cyc]);
            end
        end
    end

    // Observation of completed events for the literal pin checks
    always @(negedge clk) begin
        if (wr_en) begin
            last_wr_data = wr_data;
            last_wr_addr = wr_addr;
        end
        if (done) begin
            n_done++;
            last_done_cyc = cyc;
        end
    end

    function automatic bit condHolds(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cf, v, base;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: return (c[0] == 1'b0);
        endcase
        return c[0] ? !base : base;
    endfunction

    function automatic logic [31:0] mread(input logic [3:0] idx);
        return (idx == 4'd0) ? ID : mcreg[idx];
    endfunction

    function automatic void mwrite(input logic [3:0] idx, input logic [31:0] val);
        if (idx != 4'd0) mcreg[idx] = val;
    endfunction

    // Predict the outcome of one instruction issued in cycle k
    task automatic modelInstr(input logic [31:0] w, input logic [31:0] f, input int k, output int lat);
        logic [3:0] crn, crd, crm, opc1;
        bit is_cdp, is_mrc, is_mcr, u;
        crn = w[19:16]; crd = w[15:12]; crm = w[3:0]; opc1 = w[23:20];
        is_cdp = (w[27:24] == 4'hE) && !w[4];
        is_mrc = (w[27:24] == 4'hE) && w[4] && w[20];
        is_mcr = (w[27:24] == 4'hE) && w[4] && !w[20];
        u = 1'b0;
        lat = 3;
        if (condHolds(w[31:28], f[31:28])) begin
            if (w[11:8] != 4'd15 || !(is_cdp || is_mrc || is_mcr)) begin
                u = 1'b1;
            end else if (is_mrc) begin
                if (crd != 4'd15) begin
                    exp_wr_en[k+2]   = 1'b1;
                    exp_wr_addr[k+2] = crd;
                    exp_wr_data[k+2] = mread(crn);
                end
            end else if (is_mcr) begin
                lat = 4;
                exp_rd_en[k+2]   = 1'b1;
                exp_rd_addr[k+2] = crd;
                mwrite(crn, cpu_regs[crd]);
            end else begin
                case (opc1)
                    4'd0:    mwrite(crd, mread(crn) + mread(crm));
                    4'd1:    mwrite(crd, mread(crn) ^ mread(crm));
                    default: u = 1'b1;
                endcase
            end
        end
        exp_done[k+lat] = 1'b1;
        exp_und[k+lat]  = u;
    endtask

    // Issue one instruction, hold dav through done plus 'hold' cycles, then drop it
    task automatic applyStimulus(input logic [31:0] w, input logic [31:0] f, input int hold, output int k);
        int lat;
        k = cyc;
        modelInstr(w, f, k, lat);
        word = w;
        cpsr = f;
        dav  = 1'b1;
        repeat (lat + hold) @(posedge clk);
        #1;
        dav = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        int d0;
        for (int i = 0; i < 16; i++) begin
            mcreg[i]    = '0;
            cpu_regs[i] = 32'h1000_0000 + i;
        end
        rst_n = 1'b1; clear = 1'b0; dav = 1'b0; word = '0; cpsr = '0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_done",    {31'd0, done},  32'd0);
        checkOutput("rst_und",     {31'd0, und},   32'd0);
        checkOutput("rst_rd_en",   {31'd0, rd_en}, 32'd0);
        checkOutput("rst_wr_en",   {31'd0, wr_en}, 32'd0);
        checkOutput("rst_wr_data", wr_data,        32'd0);
        check_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] MRC of ID register");
        applyStimulus(32'hEE10_3F10, 32'h0, 0, k);
        checkOutput("t1_wr_data", last_wr_data, ID);
        checkOutput("t1_wr_addr", {28'd0, last_wr_addr}, 32'd3);
        checkOutput("t1_latency", last_done_cyc - k, 32'd3);
        applyStimulus(32'hEE15_2F10, 32'h0, 0, k);
        checkOutput("t1_c5_reset", last_wr_data, 32'd0);

        $display("[TB] MCR then MRC");
        cpu_regs[5] = 32'hDEAD_BEEF;
        applyStimulus(32'hEE02_5F10, 32'h0, 0, k);
        checkOutput("t2_latency", last_done_cyc - k, 32'd4);
        applyStimulus(32'hEE12_1F10, 32'h0, 0, k);
        checkOutput("t2_readback", last_wr_data, 32'hDEAD_BEEF);

        $display("[TB] CDP add and xor");
        cpu_regs[6] = 32'hFFFF_FFFF;
        cpu_regs[7] = 32'h0000_0001;
        applyStimulus(32'hEE02_6F10, 32'h0, 0, k);
        applyStimulus(32'hEE03_7F10, 32'h0, 0, k);
        applyStimulus(32'hEE02_4F03, 32'h0, 0, k);
        applyStimulus(32'hEE14_1F10, 32'h0, 0, k);
        checkOutput("t3_add_wrap", last_wr_data, 32'h0000_0000);
        applyStimulus(32'hEE12_4F03, 32'h0, 0, k);
        applyStimulus(32'hEE14_1F10, 32'h0, 0, k);
        checkOutput("t3_xor", last_wr_data, 32'hFFFF_FFFE);
        applyStimulus(32'hEE02_0F03, 32'h0, 0, k);
        applyStimulus(32'hEE10_3F10, 32'h0, 0, k);
        checkOutput("t3_c0_ro", last_wr_data, ID);

        $display("[TB] conditions and undefined");
        applyStimulus(32'h0E14_1F10, 32'h0000_0000, 0, k);
        applyStimulus(32'h0E14_1F10, 32'h4000_0000, 0, k);
        applyStimulus(32'hEE10_3E10, 32'h0, 0, k);
        applyStimulus(32'hED9F_5F00, 32'h0, 0, k);
        applyStimulus(32'hEE22_4F03, 32'h0, 0, k);
        applyStimulus(32'hEE10_FF10, 32'h0, 0, k);
        applyStimulus(32'hBE14_2F10, 32'h8000_0000, 0, k);
        applyStimulus(32'hCE14_2F10, 32'h4000_0000, 0, k);
        applyStimulus(32'h8E14_2F10, 32'h2000_0000, 0, k);
        applyStimulus(32'hEE02_5F10, 32'h0, 0, k);

        $display("[TB] held dav");
        d0 = n_done;
        applyStimulus(32'hEE14_1F10, 32'h0, 10, k);
        checkOutput("t5_one_done", n_done - d0, 32'd1);
        applyStimulus(32'hEE12_1F10, 32'h0, 0, k);
        checkOutput("t5_second", n_done - d0, 32'd2);

        $display("[TB] clear during MCR read");
        cpu_regs[8] = 32'h1234_5678;
        k = cyc;
        exp_rd_en[k+2]   = 1'b1;
        exp_rd_addr[k+2] = 4'd8;
        word = 32'hEE02_8F10; cpsr = '0; dav = 1'b1;
        repeat (2) @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        repeat (3) @(posedge clk);
        #1 dav = 1'b0;
        @(posedge clk); #1;
        applyStimulus(32'hEE12_1F10, 32'h0, 0, k);
        checkOutput("t6_clear_keep", last_wr_data, 32'hDEAD_BEEF);

        $display("[TB] reset in EXEC");
        word = 32'hEE14_3F10; cpsr = '0; dav = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_done",    {31'd0, done},    32'd0);
        checkOutput("t6_rst_rd_addr", {28'd0, rd_addr}, 32'd0);
        checkOutput("t6_rst_wr_addr", {28'd0, wr_addr}, 32'd0);
        checkOutput("t6_rst_wr_data", wr_data,          32'd0);
        dav = 1'b0;
        for (int i = 0; i < 16; i++) mcreg[i] = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        applyStimulus(32'hEE12_1F10, 32'h0, 0, k);
        checkOutput("t6_bank_cleared", last_wr_data, 32'd0);

        repeat (3) @(posedge clk);
        #1 check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
